alu_muldiv: RTL and testbench

- Sequential multiply/divide unit for the S1C88 core. It is the counterpart to the combinational ALU.
- Executes MLT (HL = L * A) and DIV (HL / A, giving L = quotient and H = remainder).
- The microcode sequencer drives it: a one-cycle start pulse launches an operation, and the unit returns a one-cycle done pulse with the 16-bit result and ALU-format flags.

---
 rtl/alu_muldiv.sv | 201 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Sequential MLT/DIV unit for the S1C88 core: serial shift-add multiply and restoring divide.
// Build option MULDIV_FAST_MLT_EN replaces the serial MLT with a single-cycle 8x8 multiplier.
module alu_muldiv #(
  parameter int unsigned ITER_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     op,
  input  logic [2*ITER_BITS-1:0]   A,
  input  logic [ITER_BITS-1:0]     B,
  output logic                     busy,
  output logic                     done,
  output logic                     div_zero,
  output logic [2*ITER_BITS-1:0]   R,
  output logic [3:0]               flags
);

  localparam int unsigned IW    = ITER_BITS;
  localparam int unsigned RW    = 2 * ITER_BITS;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_BITS - 1);
  localparam logic [3:0] FLAGS_OVF = 4'b0100;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [RW-1:0]      acc_q, acc_d;
  logic [RW-1:0]      mcand_q, mcand_d;
  logic [IW-1:0]      shf_q, shf_d;    // MLT multiplier / DIV dividend-low shifting into quotient
  logic [IW-1:0]      rem_q, rem_d;
  logic [IW-1:0]      dvsr_q, dvsr_d;
  logic [RW-1:0]      r_q, r_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;

  logic               b_zero;
  logic               div_ovf;
  logic [IW:0]        rem9;
  logic [IW-1:0]      rem_n;
  logic [IW-1:0]      quo_n;
  logic [RW-1:0]      acc_n;
  logic               qbit;

  assign b_zero  = (B == '0);
  assign div_ovf = (A[RW-1:IW] >= B);

`ifdef MULDIV_FAST_MLT_EN
  logic [RW-1:0] fast_prod;
  assign fast_prod = RW'(A[IW-1:0]) * RW'(B);
`endif

  function automatic logic [3:0] res_flags(input logic s, input logic z);
    return {s, 1'b0, 1'b0, z};
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      shf_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      r_q     <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      shf_q   <= shf_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      r_q     <= r_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; early-outs skip ITER entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!op) begin
`ifdef MULDIV_FAST_MLT_EN
            state_d = S_DONE;
`else
            state_d = S_ITER;
`endif
          end else if (b_zero || div_ovf) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ITER;
          end
        end
      end
      S_ITER:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath step and registered outputs; results load only on entry to DONE
  always_comb begin
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    shf_d   = shf_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    r_d     = r_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    busy_d  = (state_d != S_IDLE);
    rem9    = '0;
    rem_n   = '0;
    quo_n   = '0;
    acc_n   = '0;
    qbit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          cnt_d   = '0;
          acc_d   = '0;
          mcand_d = RW'(A[IW-1:0]);
          shf_d   = op ? A[IW-1:0] : B;
          rem_d   = A[RW-1:IW];
          dvsr_d  = B;
          if (state_d == S_DONE) begin
            done_d = 1'b1;
            if (op) begin
              r_d     = A;
              flags_d = b_zero ? 4'b0000 : FLAGS_OVF;
              dz_d    = b_zero;
            end
`ifdef MULDIV_FAST_MLT_EN
            else begin
              r_d     = fast_prod;
              flags_d = res_flags(fast_prod[RW-1], fast_prod == '0);
            end
`endif
          end
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_n = acc_q + (shf_q[0] ? mcand_q : '0);
        // 9-bit partial remainder keeps the shifted-out MSB for the compare
        rem9  = {rem_q, shf_q[IW-1]};
        qbit  = (rem9 >= {1'b0, dvsr_q});
        rem_n = qbit ? IW'(rem9 - {1'b0, dvsr_q}) : rem9[IW-1:0];
        quo_n = {shf_q[IW-2:0], qbit};
        if (op_q) begin
          rem_d = rem_n;
          shf_d = quo_n;
        end else begin
          acc_d   = acc_n;
          mcand_d = mcand_q << 1;
          shf_d   = shf_q >> 1;
        end
        if (state_d == S_DONE) begin
          done_d = 1'b1;
          if (op_q) begin
            r_d     = {rem_n, quo_n};
            flags_d = res_flags(quo_n[IW-1], quo_n == '0);
          end else begin
            r_d     = acc_n;
            flags_d = res_flags(acc_n[RW-1], acc_n == '0);
          end
        end
      end
      default: ;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign R        = r_q;
  assign flags    = flags_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed plan cases plus random MLT/DIV against an arithmetic model.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [15:0] A;
  logic [7:0]  B;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [15:0] R;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] last_r;
  logic [3:0]  last_f;

`ifdef MULDIV_FAST_MLT_EN
  localparam int MLT_LAT = 1;
`else
  localparam int MLT_LAT = 9;
`endif

  alu_muldiv #(.ITER_BITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .div_zero(div_zero), .R(R), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition of MLT/DIV
  task automatic model(input logic o, input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] r, output logic [3:0] f,
                       output logic dz, output int lat);
    int unsigned p, q, rm;
    dz = 1'b0;
    if (!o) begin
      p   = int'(a[7:0]) * int'(b);
      r   = p[15:0];
      f   = {r[15], 2'b00, r == 16'h0};
      lat = MLT_LAT;
    end else if (b == 8'h0) begin
      r = a; f = 4'b0000; dz = 1'b1; lat = 1;
    end else if (a[15:8] >= b) begin
      r = a; f = 4'b0100; lat = 1;
    end else begin
      q   = int'(a) / int'(b);
      rm  = int'(a) % int'(b);
      r   = {rm[7:0], q[7:0]};
      f   = {q[7], 2'b00, q[7:0] == 8'h0};
      lat = 9;
    end
  endtask

  task automatic quiet(input string tag, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check({tag, "/quiet"}, 32'(seen), 32'd0);
  endtask

  // Launch one op and follow it to done; extra_at > 0 pulses a second start in cycle N+extra_at
  task automatic run_op(input logic o, input logic [15:0] a, input logic [7:0] b,
                        input int extra_at, input string tag);
    logic [15:0] er;
    logic [3:0]  ef;
    logic        edz;
    int          elat;
    int          k;
    logic        got, busy_ok, hold_ok;
    model(o, a, b, er, ef, edz, elat);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 1'($urandom); A = 16'($urandom); B = 8'($urandom);
    k = 1; got = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (k <= 20) begin
      start = (k == extra_at);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (R !== last_r || flags !== last_f || div_zero !== 1'b0) hold_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, "/latency"}, got ? 32'(k) : 32'd0, 32'(elat));
    check({tag, "/R"},       32'(R),        32'(er));
    check({tag, "/flags"},   32'(flags),    32'(ef));
    check({tag, "/div_zero"}, 32'(div_zero), 32'(edz));
    check({tag, "/busy"},    32'(busy_ok),  32'd1);
    check({tag, "/hold"},    32'(hold_ok),  32'd1);
    last_r = er;
    last_f = ef;
    quiet(tag, (extra_at > 0) ? 12 : 2);
  endtask

  initial begin
    logic       ro;
    logic [7:0] rb, rhi;
    reset = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;
    last_r = '0; last_f = '0;
    repeat (2) @(negedge clk);
    check("reset/busy",     32'(busy),     32'd0);
    check("reset/done",     32'(done),     32'd0);
    check("reset/div_zero", 32'(div_zero), 32'd0);
    check("reset/R",        32'(R),        32'd0);
    check("reset/flags",    32'(flags),    32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 16'hA512, 8'h34, 0, "mlt_12x34");
    run_op(1'b0, 16'h00FF, 8'hFF, 0, "mlt_ffxff");
    run_op(1'b0, 16'h3C77, 8'h00, 0, "mlt_b0");
    run_op(1'b1, 16'h1234, 8'h56, 0, "div_basic");
    run_op(1'b1, 16'h5000, 8'h10, 0, "div_ovf");
    run_op(1'b1, 16'h1234, 8'h00, 0, "div_zero");
    run_op(1'b1, 16'hFEFF, 8'hFF, 0, "div_max");
    run_op(1'b1, 16'h1234, 8'h56, 3, "div_collide");

    // Reset in cycle N+4 of an MLT
    @(negedge clk);
    start = 1'b1; op = 1'b0; A = 16'h0012; B = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst/busy",  32'(busy),  32'd0);
    check("midrst/done",  32'(done),  32'd0);
    check("midrst/R",     32'(R),     32'd0);
    check("midrst/flags", 32'(flags), 32'd0);
    last_r = '0; last_f = '0;
    quiet("midrst", 12);
    run_op(1'b0, 16'h0012, 8'h34, 0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom);
      rb = 8'($urandom);
      if (ro && rb != 8'h0 && $urandom_range(0, 3) != 0) rhi = 8'($urandom_range(0, int'(rb) - 1));
      else rhi = 8'($urandom);
      run_op(ro, {rhi, 8'($urandom)}, rb, 0, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
